// File: rtl/ktne_countdown_ctrl_pkg.sv
// rtl/ktne_countdown_ctrl_pkg.sv - shared types and BCD helper for the countdown controller
package ktne_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUNNING  = 3'd1,
    PAUSED   = 3'd2,
    EXPLODED = 3'd3,
    DEFUSED  = 3'd4
  } state_t;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] strike_t;

  typedef struct packed {
    bcd_t mins;
    bcd_t tens;
    bcd_t ones;
  } mmss_t;

  function automatic mmss_t to_bcd(input int secs);
    mmss_t r;
    r.mins = bcd_t'(secs / 60);
    r.tens = bcd_t'((secs % 60) / 10);
    r.ones = bcd_t'(secs % 10);
    return r;
  endfunction

endpackage

// File: rtl/ktne_countdown_ctrl_if.sv
// rtl/ktne_countdown_ctrl_if.sv - game event inputs and display/status outputs of the countdown controller
interface ktne_countdown_ctrl_if;
  import ktne_pkg::*;

  logic    start;
  logic    pause;
  logic    strike;
  logic    defuse;
  bcd_t    min_bcd;
  bcd_t    sec_tens;
  bcd_t    sec_ones;
  strike_t strikes;
  state_t  state;
  logic    tick;
  logic    exploded;
  logic    defused;

  modport master (
    output start, pause, strike, defuse,
    input  min_bcd, sec_tens, sec_ones, strikes, state, tick, exploded, defused
  );

  modport slave (
    input  start, pause, strike, defuse,
    output min_bcd, sec_tens, sec_ones, strikes, state, tick, exploded, defused
  );

endinterface

// File: rtl/bcd_mmss_down.sv
// rtl/bcd_mmss_down.sv - M:SS BCD down-counter with loadable value; minutes stop at zero
module bcd_mmss_down
  import ktne_pkg::*;
#(
  parameter int START_SECS = 300
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  load_i,
  input  mmss_t load_val_i,
  input  logic  dec_i,
  output bcd_t  min_o,
  output bcd_t  tens_o,
  output bcd_t  ones_o,
  output logic  zero_o
);

  mmss_t cnt_q, cnt_d;

  assign zero_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      // zero_o guards the borrow into minutes, so minutes can never underflow
      if (cnt_q.ones != 4'd0) begin
        cnt_d.ones = cnt_q.ones - 4'd1;
      end else begin
        cnt_d.ones = 4'd9;
        if (cnt_q.tens != 4'd0) begin
          cnt_d.tens = cnt_q.tens - 4'd1;
        end else begin
          cnt_d.tens = 4'd5;
          cnt_d.mins = cnt_q.mins - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= to_bcd(START_SECS);
    else       cnt_q <= cnt_d;
  end

  assign min_o  = cnt_q.mins;
  assign tens_o = cnt_q.tens;
  assign ones_o = cnt_q.ones;

endmodule

// File: rtl/ktne_countdown_ctrl.sv
// rtl/ktne_countdown_ctrl.sv - bomb countdown sequencer: seconds prescaler, game FSM, strike speed-up
module ktne_countdown_ctrl
  import ktne_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int START_SECS  = 300,
  parameter int MAX_STRIKES = 3
) (
  input logic                  CLOCK_50,
  input logic                  reset,
  ktne_countdown_ctrl_if.slave bus
);

  localparam int      PW        = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam int      LIM1      = CLK_HZ * 3 / 4;
  localparam int      LIM2      = CLK_HZ / 2;
  localparam int      TOP0      = (CLK_HZ > 1) ? CLK_HZ - 1 : 0;
  localparam int      TOP1      = (LIM1 > 1) ? LIM1 - 1 : 0;
  localparam int      TOP2      = (LIM2 > 1) ? LIM2 - 1 : 0;
  localparam strike_t MAX_S     = strike_t'(MAX_STRIKES);
  localparam mmss_t   START_BCD = to_bcd(START_SECS);

  state_t         state_q;
  logic [PW-1:0]  presc_q;
  logic [PW-1:0]  presc_top;
  strike_t        strikes_q;
  strike_t        strikes_inc;
  logic           tick_q, exploded_q, defused_q;
  logic           wrap, last_sec, dec_en, zero;
  bcd_t           mins, tens, ones;

  always_comb begin
    case (strikes_q)
      2'd0:    presc_top = PW'(TOP0);
      2'd1:    presc_top = PW'(TOP1);
      default: presc_top = PW'(TOP2);
    endcase
  end

  assign wrap        = (presc_q == presc_top);
  assign last_sec    = (mins == 4'd0) && (tens == 4'd0) && (ones == 4'd1);
  assign strikes_inc = (strikes_q == MAX_S) ? strikes_q : strikes_q + 2'd1;
  // Higher-priority events in the same cycle swallow the decrement
  assign dec_en      = (state_q == RUNNING) && !bus.defuse && !bus.strike && !bus.pause
                       && wrap && !zero;

  bcd_mmss_down #(.START_SECS(START_SECS)) u_digits (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .load_i     (state_q == IDLE),
    .load_val_i (START_BCD),
    .dec_i      (dec_en),
    .min_o      (mins),
    .tens_o     (tens),
    .ones_o     (ones),
    .zero_o     (zero)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      strikes_q  <= '0;
      tick_q     <= 1'b0;
      exploded_q <= 1'b0;
      defused_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= RUNNING;
            presc_q <= '0;
          end
        end
        RUNNING: begin
          if (bus.defuse) begin
            state_q   <= DEFUSED;
            defused_q <= 1'b1;
          end else if (bus.strike) begin
            strikes_q <= strikes_inc;
            presc_q   <= '0;
            if (strikes_inc == MAX_S) begin
              state_q    <= EXPLODED;
              exploded_q <= 1'b1;
            end
          end else if (bus.pause) begin
            state_q <= PAUSED;
          end else if (wrap) begin
            presc_q <= '0;
            tick_q  <= !zero;
            if (last_sec || zero) begin
              state_q    <= EXPLODED;
              exploded_q <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        PAUSED: begin
          if (bus.pause || bus.start) state_q <= RUNNING;
        end
        default: ;
      endcase
    end
  end

  assign bus.state    = state_q;
  assign bus.strikes  = strikes_q;
  assign bus.tick     = tick_q;
  assign bus.exploded = exploded_q;
  assign bus.defused  = defused_q;
  assign bus.min_bcd  = mins;
  assign bus.sec_tens = tens;
  assign bus.sec_ones = ones;

endmodule

// File: doc/ktne_countdown_ctrl.md
Name: ktne_countdown_ctrl

Overview:
- Game-level sequencer for the bomb countdown timer.
- Generates the seconds tick from CLOCK_50 and holds the M:SS remaining time as BCD.
- Sequences IDLE/RUNNING/PAUSED/EXPLODED/DEFUSED from start, pause, strike and defuse events.
- Speeds the countdown as strikes accumulate; drives the digits that feed the HEX2..HEX0 seven-segment decoders.

Parameters:
- CLK_HZ, 50_000_000: input clock frequency; the nominal tick period is CLK_HZ cycles.
- START_SECS, 300: initial time in seconds; legal range 1..599, displayed as M:SS.
- MAX_STRIKES, 3: strike count that detonates; legal range 1..3.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse, synchronous, debounced.
- pause  in  1  one-cycle pulse; toggles pause.
- strike  in  1  one-cycle pulse from a module failure.
- defuse  in  1  one-cycle pulse when all modules are solved.
- min_bcd  out  4  minutes digit (HEX2).
- sec_tens  out  4  seconds tens digit, 0..5 (HEX1).
- sec_ones  out  4  seconds ones digit, 0..9 (HEX0).
- strikes  out  2  current strike count.
- state  out  3  encoded FSM state (package enum).
- tick  out  1  one-cycle pulse on every applied decrement.
- exploded  out  1  high in EXPLODED.
- defused  out  1  high in DEFUSED.

Behaviour:
- Reset (async, any state): state=IDLE; digits=START_SECS in BCD; strikes=0; prescaler=0; tick=0; exploded=0; defused=0.
- IDLE:
  - Digits held at START_SECS.
  - start -> RUNNING; prescaler cleared.
  - All other inputs ignored.
- RUNNING:
  - Prescaler counts every cycle up to LIMIT-1, then wraps to 0 and asserts tick that cycle.
  - LIMIT depends on strikes: 0 -> CLK_HZ; 1 -> CLK_HZ*3/4; 2 -> CLK_HZ/2. Integer division.
  - The digits register updates at the tick edge.
- BCD decrement (minutes never wrap):
  - sec_ones 0 -> 9 and borrow from sec_tens.
  - sec_tens 0 -> 5 and borrow from min_bcd.
- Tick that leaves 0:00 -> state=EXPLODED on the same edge. Digits show 0:00.
- strike in RUNNING:
  - strikes+1 and prescaler cleared.
  - If the new count equals MAX_STRIKES -> EXPLODED; digits frozen at their current value.
- pause in RUNNING -> PAUSED.
- PAUSED:
  - Prescaler and digits frozen.
  - pause or start -> RUNNING; the prescaler resumes from its held value.
  - strike and defuse ignored.
- defuse in RUNNING -> DEFUSED; digits frozen.
- Simultaneous events in RUNNING, priority highest first:
  - defuse > strike > pause > tick.
  - Defuse on the same cycle as the final tick: DEFUSED, digits keep the pre-decrement value, no tick pulse.
  - Strike with tick: strike handled, decrement dropped.
  - Pause with tick: PAUSED, decrement dropped.
- EXPLODED and DEFUSED are terminal:
  - All inputs ignored; only reset leaves.
  - Flags stay high; tick=0.
- tick is asserted only when a decrement is actually applied; its latency is 0 relative to the digit update.
- strikes saturates at MAX_STRIKES.
- Reset asserted mid-countdown returns to IDLE immediately, with no wait for a clock edge.

Decomposition:
- ktne_pkg holds:
  - enum state_t {IDLE, RUNNING, PAUSED, EXPLODED, DEFUSED}.
  - typedef bcd_t (logic [3:0]).
  - typedef strike_t (logic [1:0]).
  - Function to_bcd(secs) returning the M, S-tens and S-ones digits.
- Sub-module bcd_mmss_down:
  - Inputs: load, load value, dec enable.
  - Outputs: three digits and a zero flag.
  - Owns the borrow chain.
- Prescaler and FSM stay in ktne_countdown_ctrl.

Test Plan (CLK_HZ=8, START_SECS=65, MAX_STRIKES=3):
1. reset, then start, run 8 cycles:
   - 1:05 -> 1:04.
   - tick is high exactly once, on cycle 8 after start.
2. Run from 1:00:
   - Next tick shows 0:59, borrowing across minutes and tens.
   - Later, 0:10 -> 0:09.
3. Run to the end:
   - The tick leaving 0:01 shows 0:00, state=EXPLODED, exploded=1.
   - Further start/strike pulses leave all outputs unchanged.
4. Strike at 1:03:
   - strikes=1; the next tick comes 6 cycles later.
   - A second strike gives a 4-cycle period.
   - A third strike -> EXPLODED with digits frozen.
5. pause at 0:50 with prescaler=5, hold 20 cycles:
   - No change while paused.
   - pause again: the tick arrives 3 cycles later.
6. defuse and tick on the same cycle at 0:30:
   - DEFUSED with digits 0:30, tick=0.
   - Asynchronous reset mid-cycle -> IDLE with 1:05 before the next edge.
